hazard_fwd_ctrl: RTL and testbench

- Generates pipeline-control and operand-forwarding signals consumed by the ID/EX pipeline register: flush, fwd_rD1e_EX/fwd_rD2e_EX and the forwarded operands.
- Tracks destinations of in-flight instructions (EX/MEM/WB) in an internal scoreboard.
- Resolves EX>MEM>WB forwarding, inserts load-use bubbles, flushes on taken branch/jump, and freezes the pipeline while data memory is busy.

---
 rtl/hazard_pkg.sv | 33 +++
 rtl/fwd_mux.sv | 54 +++++
 rtl/hazard_fwd_ctrl.sv | 153 +++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Types shared by the hazard/forwarding unit and the decoder: scoreboard entry,
// controller state and the write-back select code that marks a load.
package hazard_pkg;

    localparam logic [1:0] WD_SEL_DRAM = 2'd1;

    typedef struct packed {
        logic       valid;
        logic [4:0] wr;
        logic       rf_we;
        logic       is_load;
    } sb_entry_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    // x0 writes and non-writing instructions never occupy a live entry.
    function automatic sb_entry_t make_entry(input logic       instr_valid,
                                             input logic [4:0] wr,
                                             input logic       rf_we,
                                             input logic [1:0] wd_sel);
        sb_entry_t e;
        e.valid   = instr_valid && rf_we && (wr != 5'd0);
        e.wr      = wr;
        e.rf_we   = rf_we;
        e.is_load = (wd_sel == WD_SEL_DRAM);
        return e;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// One-operand forwarding select: youngest matching in-flight producer wins
// (EX > MEM > WB); a load still in EX cannot forward and raises load_use.
module fwd_mux
    import hazard_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs,
    input  logic            rs_used,
    input  logic [XLEN-1:0] rd_id,
    input  sb_entry_t       sb_ex,
    input  sb_entry_t       sb_mem,
    input  sb_entry_t       sb_wb,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] mem_wd,
    input  logic [XLEN-1:0] wb_wd,
    output logic            fwd_en,
    output logic [XLEN-1:0] fwd_data,
    output logic            load_use
);

    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    function automatic logic hit(input sb_entry_t e, input logic [4:0] r, input logic used);
        return used && (r != 5'd0) && e.valid && e.rf_we && (e.wr == r);
    endfunction

    assign hit_ex  = hit(sb_ex,  rs, rs_used);
    assign hit_mem = hit(sb_mem, rs, rs_used);
    assign hit_wb  = hit(sb_wb,  rs, rs_used);

    always_comb begin
        fwd_en   = 1'b0;
        fwd_data = rd_id;
        load_use = 1'b0;
        if (hit_ex) begin
            if (sb_ex.is_load) begin
                load_use = 1'b1;
            end else begin
                fwd_en   = 1'b1;
                fwd_data = ex_result;
            end
        end else if (hit_mem) begin
            fwd_en   = 1'b1;
            fwd_data = mem_wd;
        end else if (hit_wb) begin
            fwd_en   = 1'b1;
            fwd_data = wb_wd;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard controller: scoreboard of EX/MEM/WB destinations, operand
// forwarding, load-use bubbles, redirect flushes and dmem freeze. HAZARD_PERF_EN adds event counters.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int SB_DEPTH = 3,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid_id_i,
    input  logic [4:0]      rs1_id_i,
    input  logic [4:0]      rs2_id_i,
    input  logic            rs1_used_id_i,
    input  logic            rs2_used_id_i,
    input  logic [4:0]      wr_id_i,
    input  logic            rf_we_id_i,
    input  logic [1:0]      wd_sel_id_i,
    input  logic [XLEN-1:0] rD1_id_i,
    input  logic [XLEN-1:0] rD2_id_i,
    input  logic [XLEN-1:0] ex_result_i,
    input  logic [XLEN-1:0] mem_wd_i,
    input  logic [XLEN-1:0] wb_wd_i,
    input  logic            redirect_ex_i,
    input  logic            dmem_busy_i,
    output logic            stall_if_o,
    output logic            flush_if_id_o,
    output logic            flush_id_ex_o,
    output logic            freeze_o,
    output logic            fwd_rD1e_EX,
    output logic            fwd_rD2e_EX,
    output logic [XLEN-1:0] fwd_rD1_EX,
    output logic [XLEN-1:0] fwd_rD2_EX,
    output hz_state_e       dbg_state_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [XLEN-1:0] perf_lu_stall_o,
    output logic [XLEN-1:0] perf_redirect_o,
    output logic [XLEN-1:0] perf_freeze_o
`endif
);

    localparam int SB_EX  = 0;
    localparam int SB_MEM = 1;
    localparam int SB_WB  = 2;

    sb_entry_t sb_q [SB_DEPTH];
    sb_entry_t id_entry;
    hz_state_e state_q;
    logic      lu1;
    logic      lu2;
    logic      load_use;
    logic      lu_stall;

    assign id_entry = make_entry(instr_valid_id_i, wr_id_i, rf_we_id_i, wd_sel_id_i);

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs        (rs1_id_i),
        .rs_used   (rs1_used_id_i),
        .rd_id     (rD1_id_i),
        .sb_ex     (sb_q[SB_EX]),
        .sb_mem    (sb_q[SB_MEM]),
        .sb_wb     (sb_q[SB_WB]),
        .ex_result (ex_result_i),
        .mem_wd    (mem_wd_i),
        .wb_wd     (wb_wd_i),
        .fwd_en    (fwd_rD1e_EX),
        .fwd_data  (fwd_rD1_EX),
        .load_use  (lu1)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs        (rs2_id_i),
        .rs_used   (rs2_used_id_i),
        .rd_id     (rD2_id_i),
        .sb_ex     (sb_q[SB_EX]),
        .sb_mem    (sb_q[SB_MEM]),
        .sb_wb     (sb_q[SB_WB]),
        .ex_result (ex_result_i),
        .mem_wd    (mem_wd_i),
        .wb_wd     (wb_wd_i),
        .fwd_en    (fwd_rD2e_EX),
        .fwd_data  (fwd_rD2_EX),
        .load_use  (lu2)
    );

    assign load_use    = lu1 | lu2;
    assign dbg_state_o = state_q;

    // Freeze beats redirect beats load-use; LU_STALL blocks a back-to-back bubble.
    always_comb begin
        freeze_o      = 1'b0;
        stall_if_o    = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        lu_stall      = 1'b0;
        if (!rst) begin
            if (dmem_busy_i) begin
                freeze_o   = 1'b1;
                stall_if_o = 1'b1;
            end else if (redirect_ex_i) begin
                flush_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
            end else if (load_use && (state_q != LU_STALL)) begin
                lu_stall      = 1'b1;
                stall_if_o    = 1'b1;
                flush_id_ex_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            case (state_q)
                RUN, LU_STALL, MEM_WAIT: begin
                    if (dmem_busy_i)   state_q <= MEM_WAIT;
                    else if (lu_stall) state_q <= LU_STALL;
                    else               state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SB_DEPTH; i++) sb_q[i] <= '0;
        end else if (!freeze_o) begin
            for (int i = SB_DEPTH - 1; i > 0; i--) sb_q[i] <= sb_q[i-1];
            sb_q[SB_EX] <= (instr_valid_id_i && !flush_id_ex_o) ? id_entry : '0;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_stall_o <= '0;
            perf_redirect_o <= '0;
            perf_freeze_o   <= '0;
        end else begin
            if (lu_stall && (perf_lu_stall_o != '1))
                perf_lu_stall_o <= perf_lu_stall_o + 1'b1;
            if (flush_if_id_o && (perf_redirect_o != '1))
                perf_redirect_o <= perf_redirect_o + 1'b1;
            if (freeze_o && (perf_freeze_o != '1))
                perf_freeze_o <= perf_freeze_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed scenarios plus random traffic against an
// in-flight instruction list model.
module tb_hazard_fwd_ctrl;
    import hazard_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            instr_valid_id_i;
    logic [4:0]      rs1_id_i, rs2_id_i, wr_id_i;
    logic            rs1_used_id_i, rs2_used_id_i, rf_we_id_i;
    logic [1:0]      wd_sel_id_i;
    logic [XLEN-1:0] rD1_id_i, rD2_id_i, ex_result_i, mem_wd_i, wb_wd_i;
    logic            redirect_ex_i, dmem_busy_i;
    logic            stall_if_o, flush_if_id_o, flush_id_ex_o, freeze_o;
    logic            fwd_rD1e_EX, fwd_rD2e_EX;
    logic [XLEN-1:0] fwd_rD1_EX, fwd_rD2_EX;
    hz_state_e       dbg_state_o;
`ifdef HAZARD_PERF_EN
    logic [XLEN-1:0] perf_lu_stall_o, perf_redirect_o, perf_freeze_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0] rd;
        logic       ld;
    } mrec_t;
    mrec_t pipe_q[$];

    hazard_fwd_ctrl #(.SB_DEPTH(3), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .instr_valid_id_i(instr_valid_id_i),
        .rs1_id_i(rs1_id_i), .rs2_id_i(rs2_id_i),
        .rs1_used_id_i(rs1_used_id_i), .rs2_used_id_i(rs2_used_id_i),
        .wr_id_i(wr_id_i), .rf_we_id_i(rf_we_id_i), .wd_sel_id_i(wd_sel_id_i),
        .rD1_id_i(rD1_id_i), .rD2_id_i(rD2_id_i),
        .ex_result_i(ex_result_i), .mem_wd_i(mem_wd_i), .wb_wd_i(wb_wd_i),
        .redirect_ex_i(redirect_ex_i), .dmem_busy_i(dmem_busy_i),
        .stall_if_o(stall_if_o), .flush_if_id_o(flush_if_id_o),
        .flush_id_ex_o(flush_id_ex_o), .freeze_o(freeze_o),
        .fwd_rD1e_EX(fwd_rD1e_EX), .fwd_rD2e_EX(fwd_rD2e_EX),
        .fwd_rD1_EX(fwd_rD1_EX), .fwd_rD2_EX(fwd_rD2_EX),
        .dbg_state_o(dbg_state_o)
`ifdef HAZARD_PERF_EN
        ,
        .perf_lu_stall_o(perf_lu_stall_o),
        .perf_redirect_o(perf_redirect_o),
        .perf_freeze_o(perf_freeze_o)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        instr_valid_id_i = 0; rs1_id_i = 0; rs2_id_i = 0; wr_id_i = 0;
        rs1_used_id_i = 0; rs2_used_id_i = 0; rf_we_id_i = 0; wd_sel_id_i = 0;
        rD1_id_i = 32'hA1A1_0001; rD2_id_i = 32'hB2B2_0002;
        ex_result_i = 0; mem_wd_i = 0; wb_wd_i = 0;
        redirect_ex_i = 0; dmem_busy_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [4:0] wr, input logic [1:0] wd_sel);
        instr_valid_id_i = 1; wr_id_i = wr; rf_we_id_i = 1; wd_sel_id_i = wd_sel;
        rs1_used_id_i = 0; rs2_used_id_i = 0;
        tick();
    endtask

    task automatic read_regs(input logic [4:0] r1, input logic u1,
                             input logic [4:0] r2, input logic u2);
        instr_valid_id_i = 1; wr_id_i = 0; rf_we_id_i = 0; wd_sel_id_i = 0;
        rs1_id_i = r1; rs1_used_id_i = u1; rs2_id_i = r2; rs2_used_id_i = u2;
    endtask

    // ---------------- reference model ----------------
    function automatic void mdl_fwd(input logic [4:0] rs, input logic used,
                                    input logic [XLEN-1:0] rdv,
                                    output logic en, output logic [XLEN-1:0] d,
                                    output logic lu);
        logic found;
        en = 0; d = rdv; lu = 0; found = 0;
        if (used && rs != 0) begin
            for (int i = 0; i < 3; i++) begin
                if (!found && pipe_q[i].rd == rs) begin
                    found = 1;
                    if (i == 0 && pipe_q[i].ld) lu = 1;
                    else begin
                        en = 1;
                        d  = (i == 0) ? ex_result_i : (i == 1) ? mem_wd_i : wb_wd_i;
                    end
                end
            end
        end
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1;
        clear_inputs();
        dmem_busy_i = 1;
        redirect_ex_i = 1;
        #4;
        n_tests++;
        if ({freeze_o, stall_if_o, flush_if_id_o, flush_id_ex_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b need 0000",
                     {freeze_o, stall_if_o, flush_if_id_o, flush_id_ex_o});
        end
        tick();
        clear_inputs();
        tick();
        rst = 0;
        #4;
        n_tests++;
        if (dbg_state_o !== RUN || fwd_rD1e_EX !== 0 || fwd_rD2e_EX !== 0 ||
            fwd_rD1_EX !== rD1_id_i || fwd_rD2_EX !== rD2_id_i) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d en=%b%b d1=%h d2=%h need RUN, 00, rD passthrough",
                     dbg_state_o, fwd_rD1e_EX, fwd_rD2e_EX, fwd_rD1_EX, fwd_rD2_EX);
        end
        tick();
    endtask

    task automatic test_ex_forward();
        do_reset();
        issue(5'd5, 2'd0);
        read_regs(5'd5, 1, 5'd0, 0);
        ex_result_i = 32'h1234;
        #4;
        n_tests++;
        if (fwd_rD1e_EX !== 1 || fwd_rD1_EX !== 32'h1234 || stall_if_o !== 0) begin
            n_fail++;
            $display("FAIL ex_forward: en=%b d=%h stall=%b need 1 00001234 0",
                     fwd_rD1e_EX, fwd_rD1_EX, stall_if_o);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        issue(5'd6, WD_SEL_DRAM);
        read_regs(5'd0, 0, 5'd6, 1);
        mem_wd_i = 32'hCAFEBABE;
        #4;
        n_tests++;
        if ({stall_if_o, flush_id_ex_o, flush_if_id_o, fwd_rD2e_EX} !== 4'b1100 || dbg_state_o !== RUN) begin
            n_fail++;
            $display("FAIL load_use_detect: stall/fidex/fifid/en=%b state=%0d need 1100 RUN",
                     {stall_if_o, flush_id_ex_o, flush_if_id_o, fwd_rD2e_EX}, dbg_state_o);
        end
        tick();
        #4;
        n_tests++;
        if (stall_if_o !== 0 || fwd_rD2e_EX !== 1 || fwd_rD2_EX !== 32'hCAFEBABE || dbg_state_o !== LU_STALL) begin
            n_fail++;
            $display("FAIL load_use_fwd: stall=%b en=%b d=%h state=%0d need 0 1 cafebabe LU_STALL",
                     stall_if_o, fwd_rD2e_EX, fwd_rD2_EX, dbg_state_o);
        end
        tick();
        #4;
        n_tests++;
        if (dbg_state_o !== RUN || stall_if_o !== 0) begin
            n_fail++;
            $display("FAIL load_use_exit: state=%0d stall=%b need RUN 0", dbg_state_o, stall_if_o);
        end
        tick();
    endtask

    task automatic test_priority_x0();
        logic [XLEN-1:0] exp_v [4];
        exp_v[0] = 32'h11; exp_v[1] = 32'h22; exp_v[2] = 32'h33; exp_v[3] = 32'hA1A1_0001;
        do_reset();
        issue(5'd5, 2'd0);
        issue(5'd5, 2'd0);
        issue(5'd5, 2'd0);
        read_regs(5'd5, 1, 5'd0, 0);
        ex_result_i = 32'h11; mem_wd_i = 32'h22; wb_wd_i = 32'h33;
        for (int k = 0; k < 4; k++) begin
            #4;
            n_tests++;
            if (fwd_rD1e_EX !== (k < 3) || fwd_rD1_EX !== exp_v[k]) begin
                n_fail++;
                $display("FAIL priority_%0d: en=%b d=%h need %b %h",
                         k, fwd_rD1e_EX, fwd_rD1_EX, (k < 3), exp_v[k]);
            end
            tick();
        end
        do_reset();
        issue(5'd0, WD_SEL_DRAM);
        read_regs(5'd0, 1, 5'd0, 1);
        ex_result_i = 32'h77;
        #4;
        n_tests++;
        if ({stall_if_o, flush_id_ex_o, fwd_rD1e_EX, fwd_rD2e_EX} !== 4'b0 || fwd_rD1_EX !== rD1_id_i) begin
            n_fail++;
            $display("FAIL x0_no_fwd: stall/fidex/en1/en2=%b d1=%h need 0000 %h",
                     {stall_if_o, flush_id_ex_o, fwd_rD1e_EX, fwd_rD2e_EX}, fwd_rD1_EX, rD1_id_i);
        end
        tick();
    endtask

    task automatic test_lu_redirect();
        do_reset();
        issue(5'd6, WD_SEL_DRAM);
        read_regs(5'd0, 0, 5'd6, 1);
        redirect_ex_i = 1;
        #4;
        n_tests++;
        if ({flush_if_id_o, flush_id_ex_o, stall_if_o, freeze_o} !== 4'b1100) begin
            n_fail++;
            $display("FAIL lu_redirect: fifid/fidex/stall/freeze=%b need 1100",
                     {flush_if_id_o, flush_id_ex_o, stall_if_o, freeze_o});
        end
        tick();
        redirect_ex_i = 0;
        #4;
        n_tests++;
        if (dbg_state_o !== RUN) begin
            n_fail++;
            $display("FAIL lu_redirect_state: state=%0d need RUN", dbg_state_o);
        end
        tick();
    endtask

    task automatic test_busy_during_lu();
        do_reset();
        issue(5'd6, WD_SEL_DRAM);
        read_regs(5'd0, 0, 5'd6, 1);
        mem_wd_i = 32'hCAFEBABE;
        dmem_busy_i = 1;
        for (int k = 0; k < 3; k++) begin
            #4;
            n_tests++;
            if ({freeze_o, stall_if_o, flush_if_id_o, flush_id_ex_o, fwd_rD2e_EX} !== 5'b11000 ||
                (k > 0 && dbg_state_o !== MEM_WAIT)) begin
                n_fail++;
                $display("FAIL busy_freeze_%0d: frz/stall/fifid/fidex/en=%b state=%0d need 11000",
                         k, {freeze_o, stall_if_o, flush_if_id_o, flush_id_ex_o, fwd_rD2e_EX}, dbg_state_o);
            end
            tick();
        end
        dmem_busy_i = 0;
        #4;
        n_tests++;
        if ({freeze_o, stall_if_o, flush_id_ex_o, fwd_rD2e_EX} !== 4'b0110) begin
            n_fail++;
            $display("FAIL busy_resume_stall: frz/stall/fidex/en=%b need 0110",
                     {freeze_o, stall_if_o, flush_id_ex_o, fwd_rD2e_EX});
        end
        tick();
        #4;
        n_tests++;
        if (stall_if_o !== 0 || fwd_rD2e_EX !== 1 || fwd_rD2_EX !== 32'hCAFEBABE) begin
            n_fail++;
            $display("FAIL busy_resume_fwd: stall=%b en=%b d=%h need 0 1 cafebabe",
                     stall_if_o, fwd_rD2e_EX, fwd_rD2_EX);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        dmem_busy_i = 1;
        tick();
        tick();
        #4;
        n_tests++;
        if (dbg_state_o !== MEM_WAIT) begin
            n_fail++;
            $display("FAIL mid_wait_entry: state=%0d need MEM_WAIT", dbg_state_o);
        end
        tick();
        rst = 1;
        tick();
        rst = 0;
        clear_inputs();
        #4;
        n_tests++;
        if (dbg_state_o !== RUN ||
            {freeze_o, stall_if_o, flush_if_id_o, flush_id_ex_o, fwd_rD1e_EX, fwd_rD2e_EX} !== 6'b0) begin
            n_fail++;
            $display("FAIL mid_wait_reset: state=%0d outs=%b need RUN 000000", dbg_state_o,
                     {freeze_o, stall_if_o, flush_if_id_o, flush_id_ex_o, fwd_rD1e_EX, fwd_rD2e_EX});
        end
`ifdef HAZARD_PERF_EN
        n_tests++;
        if (perf_lu_stall_o !== 0 || perf_redirect_o !== 0 || perf_freeze_o !== 0) begin
            n_fail++;
            $display("FAIL perf_cleared: lu=%0d rd=%0d fz=%0d need 0 0 0",
                     perf_lu_stall_o, perf_redirect_o, perf_freeze_o);
        end
`endif
        tick();
    endtask

    task automatic test_random();
        logic            e1, e2, l1, l2, lu_stall, prev_lu, flush;
        logic [XLEN-1:0] d1, d2;
        logic [3:0]      exp_ctrl;
        mrec_t           rec;
        do_reset();
        pipe_q.delete();
        for (int i = 0; i < 3; i++) pipe_q.push_back('{rd: 5'd0, ld: 1'b0});
        prev_lu = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            instr_valid_id_i = ($urandom_range(0, 4) != 0);
            rs1_id_i = 5'($urandom_range(0, 3)); rs2_id_i = 5'($urandom_range(0, 3));
            rs1_used_id_i = 1'($urandom_range(0, 1)); rs2_used_id_i = 1'($urandom_range(0, 1));
            wr_id_i = 5'($urandom_range(0, 3)); rf_we_id_i = ($urandom_range(0, 3) != 0);
            wd_sel_id_i = 2'($urandom_range(0, 3));
            rD1_id_i = $urandom; rD2_id_i = $urandom;
            ex_result_i = $urandom; mem_wd_i = $urandom; wb_wd_i = $urandom;
            redirect_ex_i = ($urandom_range(0, 7) == 0);
            dmem_busy_i = ($urandom_range(0, 7) == 0);
            mdl_fwd(rs1_id_i, rs1_used_id_i, rD1_id_i, e1, d1, l1);
            mdl_fwd(rs2_id_i, rs2_used_id_i, rD2_id_i, e2, d2, l2);
            lu_stall = 0;
            if (dmem_busy_i)        exp_ctrl = 4'b1100;
            else if (redirect_ex_i) exp_ctrl = 4'b0011;
            else if ((l1 || l2) && !prev_lu) begin
                exp_ctrl = 4'b0101;
                lu_stall = 1;
            end else                exp_ctrl = 4'b0000;
            #4;
            n_tests++;
            if ({freeze_o, stall_if_o, flush_if_id_o, flush_id_ex_o} !== exp_ctrl) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc %0d: frz/stall/fifid/fidex=%b need %b", cyc,
                         {freeze_o, stall_if_o, flush_if_id_o, flush_id_ex_o}, exp_ctrl);
            end
            n_tests++;
            if (fwd_rD1e_EX !== e1 || fwd_rD1_EX !== d1) begin
                n_fail++;
                $display("FAIL rand_rs1 cyc %0d: en=%b d=%h need %b %h", cyc, fwd_rD1e_EX, fwd_rD1_EX, e1, d1);
            end
            n_tests++;
            if (fwd_rD2e_EX !== e2 || fwd_rD2_EX !== d2) begin
                n_fail++;
                $display("FAIL rand_rs2 cyc %0d: en=%b d=%h need %b %h", cyc, fwd_rD2e_EX, fwd_rD2_EX, e2, d2);
            end
            @(posedge clk);
            if (!dmem_busy_i) begin
                flush  = redirect_ex_i || lu_stall;
                rec.rd = (instr_valid_id_i && !flush && rf_we_id_i) ? wr_id_i : 5'd0;
                rec.ld = (wd_sel_id_i == WD_SEL_DRAM);
                pipe_q.push_front(rec);
                void'(pipe_q.pop_back());
                prev_lu = lu_stall;
            end else begin
                prev_lu = 0;
            end
            #1;
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        tick();
        test_reset();
        test_ex_forward();
        test_load_use();
        test_priority_x0();
        test_lu_redirect();
        test_busy_during_lu();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
